scmp_ram_arbiter: RTL and testbench
===================================

Name: scmp_ram_arbiter

Overview:
Single-port arbiter for the 4 KB external RAM page of the SC/MP board. It shares the RAM between the CPU bus (RD_n/WR_n strobes plus latched page nibble) and a host port (loader or debug DMA) with a req/gnt handshake. CPU accesses always win and have fixed latency. Host accesses fill the idle RAM slots, including the slots inside a long CPU strobe after the CPU's own access has completed.

Parameters:
PAGE, 4'h1, value of the latched page nibble that selects this RAM
AW, 12, RAM address width
STARVE_CYCLES, 64, host wait count at which host_starved asserts

Ports:
clk  in  1  RAM-side clock (ram_clk domain; CPU strobes are synchronous to it)
rst  in  1  synchronous reset, active-high
cpu_page  in  4  latched page nibble (cpu_addr_latched)
cpu_addr  in  AW  CPU address
cpu_D_o  in  8  CPU write data
cpu_RD_n  in  1  CPU read strobe, active-low
cpu_WR_n  in  1  CPU write strobe, active-low
cpu_sel  out  1  comb: cpu_page==PAGE; drives the board read mux
cpu_rdata  out  8  registered CPU read data
host_req  in  1  host request level
host_we  in  1  1=write, 0=read
host_addr  in  AW  host address
host_wdata  in  8  host write data
host_gnt  out  1  1-cycle pulse: request accepted this cycle
host_rvalid  out  1  1-cycle pulse: host_rdata valid
host_rdata  out  8  host read data
host_starved  out  1  host has waited >= STARVE_CYCLES
ram_addr  out  AW  comb RAM address
ram_we  out  1  comb RAM write enable
ram_wdata  out  8  comb RAM write data
ram_rdata  in  8  RAM read data, 1-cycle synchronous latency

Behaviour:
- Reset: cpu_rdata=0, host_rdata=0, host_gnt=0, host_rvalid=0, host_starved=0, wait counter=0, pending flags cleared. The previous-strobe registers reset to the "asserted" state, so a strobe already low at reset release produces no edge. It must first go high and then low.
- Edge detect: rd_edge = !cpu_RD_n & prev_RD_high & cpu_sel. wr_edge likewise for WR_n.
- Slot allocation per cycle, in priority order:
  1. CPU read slot, in the rd_edge cycle: ram_addr=cpu_addr, ram_we=0.
  2. CPU write slot, in the cycle after wr_edge: ram_addr=cpu_addr, ram_wdata=cpu_D_o sampled in that cycle, ram_we=1.
  3. Host slot, when host_req=1 and neither CPU slot is active: ram_addr=host_addr, ram_we=host_we, ram_wdata=host_wdata, host_gnt=1.
  4. Idle: ram_we=0, ram_addr holds cpu_addr.
- CPU read latency: cpu_rdata is loaded from ram_rdata at edge+1 and is visible from edge+2. It holds until the next CPU read capture. Host reads never alter it.
- Host read: host_rvalid pulses at gnt+1 with host_rdata=ram_rdata. host_rdata holds afterwards. Back-to-back grants are allowed, one per cycle.
- Host handshake: host_req and its fields stay stable until host_gnt is sampled. A request that loses to a CPU slot is not granted that cycle and retries automatically.
- Precondition (checked by assertion, not handled): RD_n and WR_n are never low together, and each strobe is low for >= 2 clk. Under this precondition the read slot and the write slot never coincide.
- Starvation: the wait counter increments each cycle with host_req=1 & !host_gnt, saturates at STARVE_CYCLES, and clears on host_gnt or when host_req=0. host_starved = (counter == STARVE_CYCLES). This is a status output only; CPU priority is never overridden.
- Strobes while cpu_sel=0 produce no slot. If cpu_page changes mid-strobe, no new edge is generated.
- Reset mid-operation: in-flight capture and rvalid are dropped. No RAM write is issued in the reset cycle.

Test Plan:
- Reset with RD_n held low, then release: no CPU slot until RD_n goes high then low. First read of addr 0x123 (RAM=0x5A) -> cpu_rdata=0x5A at edge+2.
- CPU write: page=1, WR_n low 4 cycles, addr 0xFFF, D_o=0xC3 -> exactly one ram_we pulse at edge+1 with data 0xC3. A later read of 0xFFF returns 0xC3.
- Host req read 0x010 asserted in the same cycle as rd_edge -> host_gnt delayed 1 cycle. host_rvalid at gnt+1 with RAM[0x010]. cpu_rdata is unaffected.
- Host streaming 8 writes to 0x000..0x007 during a 6-cycle CPU read strobe -> grants fill all non-CPU cycles, all 8 bytes land, and the CPU data is correct.
- Page=2 strobes -> cpu_sel=0, no RAM slot, and the host is granted every cycle.
- Host req held while a CPU slot is forced every cycle for 70 cycles (bench override) -> host_starved rises at the 64th wait cycle and falls the cycle after host_gnt.

Source files
------------

// File: rtl/scmp_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : scmp_ram_arbiter
//  Purpose  : Single-port arbiter for the 4 KB external RAM page of the SC/MP
//             board. The CPU bus (RD_n/WR_n strobes plus latched page nibble)
//             always wins and has fixed latency. A host port with a req/gnt
//             handshake fills every RAM slot the CPU leaves idle, including
//             the slots inside a long CPU strobe after the CPU access is done.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   RAM-side clock; CPU strobes are synchronous to it
//    rst           in   synchronous reset, active-high
//    cpu_page      in   latched page nibble
//    cpu_addr      in   CPU address
//    cpu_D_o       in   CPU write data
//    cpu_RD_n      in   CPU read strobe, active-low
//    cpu_WR_n      in   CPU write strobe, active-low
//    cpu_sel       out  page match, drives the board read mux (comb)
//    cpu_rdata     out  registered CPU read data
//    host_req      in   host request level
//    host_we       in   host write (1) / read (0)
//    host_addr     in   host address
//    host_wdata    in   host write data
//    host_gnt      out  1-cycle pulse, request accepted this cycle
//    host_rvalid   out  1-cycle pulse, host_rdata valid
//    host_rdata    out  host read data, holds after the pulse
//    host_starved  out  host has waited STARVE_CYCLES or more
//    ram_addr      out  RAM address (comb)
//    ram_we        out  RAM write enable (comb)
//    ram_wdata     out  RAM write data (comb)
//    ram_rdata     in   RAM read data, one-cycle synchronous latency
// ============================================================================
module scmp_ram_arbiter #(
   parameter logic [3:0] PAGE          = 4'h1,
   parameter int         AW            = 12,
   parameter int         STARVE_CYCLES = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    cpu_page,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_D_o,
   input  logic          cpu_RD_n,
   input  logic          cpu_WR_n,
   output logic          cpu_sel,
   output logic [7:0]    cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [7:0]    host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [7:0]    host_rdata,
   output logic          host_starved,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [7:0]    ram_wdata,
   input  logic [7:0]    ram_rdata
);

   localparam int                  c_WAIT_W   = $clog2(STARVE_CYCLES + 1);
   localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(STARVE_CYCLES);

   // ------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------
   logic                r_rd_prev_high;   // RD_n was high last cycle
   logic                r_wr_prev_high;   // WR_n was high last cycle
   logic                r_wr_slot;        // CPU write slot is this cycle
   logic                r_rd_cap;         // ram_rdata holds the CPU read byte
   logic                r_host_rd_pend;   // ram_rdata holds a host read byte
   logic [7:0]          r_cpu_rdata;
   logic [7:0]          r_host_rdata_hold;
   logic [c_WAIT_W-1:0] r_wait;

   // ------------------------------------------------------------------
   // Combinational decode
   // ------------------------------------------------------------------
   logic          w_cpu_sel;
   logic          w_rd_edge;
   logic          w_wr_edge;
   logic          w_host_slot;
   logic          w_host_gnt;
   logic          w_host_rvalid;
   logic [AW-1:0] w_ram_addr;
   logic          w_ram_we;
   logic [7:0]    w_ram_wdata;

   assign w_cpu_sel = (cpu_page == PAGE);

   // Falling-edge detect. Because the previous-strobe flags reset low, a
   // strobe that is already asserted when reset lifts must first return
   // high before it can produce an access. A page change while a strobe is
   // held low cannot create an edge either, since the flag is already low.
   assign w_rd_edge = ~cpu_RD_n & r_rd_prev_high & w_cpu_sel;
   assign w_wr_edge = ~cpu_WR_n & r_wr_prev_high & w_cpu_sel;

   // The CPU read uses the edge cycle itself; the write waits one cycle so
   // that write data on the bus has settled. Everything else goes to host.
   assign w_host_slot = host_req & ~w_rd_edge & ~r_wr_slot;
   assign w_host_gnt  = w_host_slot & ~rst;

   always_comb begin
      w_ram_addr  = cpu_addr;
      w_ram_we    = 1'b0;
      w_ram_wdata = cpu_D_o;
      if (w_rd_edge) begin
         w_ram_addr = cpu_addr;
         w_ram_we   = 1'b0;
      end else if (r_wr_slot) begin
         w_ram_addr  = cpu_addr;
         w_ram_wdata = cpu_D_o;
         w_ram_we    = 1'b1;
      end else if (w_host_slot) begin
         w_ram_addr  = host_addr;
         w_ram_wdata = host_wdata;
         w_ram_we    = host_we;
      end
      // Never let a write reach the RAM while reset is asserted.
      if (rst) begin
         w_ram_we = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_prev_high    <= 1'b0;
         r_wr_prev_high    <= 1'b0;
         r_wr_slot         <= 1'b0;
         r_rd_cap          <= 1'b0;
         r_host_rd_pend    <= 1'b0;
         r_cpu_rdata       <= 8'h00;
         r_host_rdata_hold <= 8'h00;
         r_wait            <= '0;
      end else begin
         r_rd_prev_high <= cpu_RD_n;
         r_wr_prev_high <= cpu_WR_n;
         r_wr_slot      <= w_wr_edge;
         r_rd_cap       <= w_rd_edge;
         r_host_rd_pend <= w_host_gnt & ~host_we;

         if (r_rd_cap) begin
            r_cpu_rdata <= ram_rdata;
         end
         if (r_host_rd_pend) begin
            r_host_rdata_hold <= ram_rdata;
         end

         // Wait counter: counts refused request cycles, saturating.
         if (~host_req | w_host_gnt) begin
            r_wait <= '0;
         end else if (r_wait != c_WAIT_MAX) begin
            r_wait <= r_wait + 1'b1;
         end
      end
   end

   // A host read byte is presented straight from the RAM in the pulse
   // cycle and held afterwards; a pulse that would coincide with reset is
   // suppressed.
   assign w_host_rvalid = r_host_rd_pend & ~rst;

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign cpu_sel      = w_cpu_sel;
   assign cpu_rdata    = r_cpu_rdata;
   assign host_gnt     = w_host_gnt;
   assign host_rvalid  = w_host_rvalid;
   assign host_rdata   = w_host_rvalid ? ram_rdata : r_host_rdata_hold;
   assign host_starved = (r_wait == c_WAIT_MAX);
   assign ram_addr     = w_ram_addr;
   assign ram_we       = w_ram_we;
   assign ram_wdata    = w_ram_wdata;

   // ------------------------------------------------------------------
   // Bus preconditions: the CPU never drives both strobes, and each strobe
   // stays low for at least two clocks. Together these keep the read slot
   // and the write slot apart.
   // ------------------------------------------------------------------
   a_strobe_excl : assert property (@(posedge clk) disable iff (rst)
      !(!cpu_RD_n && !cpu_WR_n));
   a_rd_min_width : assert property (@(posedge clk) disable iff (rst)
      (r_rd_prev_high && !cpu_RD_n) |=> !cpu_RD_n);
   a_wr_min_width : assert property (@(posedge clk) disable iff (rst)
      (r_wr_prev_high && !cpu_WR_n) |=> !cpu_WR_n);
   a_slot_excl : assert property (@(posedge clk) disable iff (rst)
      !(w_rd_edge && r_wr_slot));

endmodule
`default_nettype wire

// File: tb/tb_scmp_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scmp_ram_arbiter
//  Purpose  : Directed self-checking bench for scmp_ram_arbiter. A RAM model
//             with one-cycle read latency sits on the RAM port; a host request
//             queue drives the host port; a cycle model of the arbitration
//             rules and a read-data scoreboard supply every expected value.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scmp_ram_arbiter;

   localparam int c_AW     = 12;
   localparam int c_STARVE = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      cpu_page;
   logic [c_AW-1:0] cpu_addr;
   logic [7:0]      cpu_D_o;
   logic            cpu_RD_n;
   logic            cpu_WR_n;
   logic            cpu_sel;
   logic [7:0]      cpu_rdata;
   logic            host_req;
   logic            host_we;
   logic [c_AW-1:0] host_addr;
   logic [7:0]      host_wdata;
   logic            host_gnt;
   logic            host_rvalid;
   logic [7:0]      host_rdata;
   logic            host_starved;
   logic [c_AW-1:0] ram_addr;
   logic            ram_we;
   logic [7:0]      ram_wdata;
   logic [7:0]      ram_rdata;

   always #5 clk = ~clk;

   scmp_ram_arbiter #(
      .PAGE          (4'h1),
      .AW            (c_AW),
      .STARVE_CYCLES (c_STARVE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_page     (cpu_page),
      .cpu_addr     (cpu_addr),
      .cpu_D_o      (cpu_D_o),
      .cpu_RD_n     (cpu_RD_n),
      .cpu_WR_n     (cpu_WR_n),
      .cpu_sel      (cpu_sel),
      .cpu_rdata    (cpu_rdata),
      .host_req     (host_req),
      .host_we      (host_we),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_gnt     (host_gnt),
      .host_rvalid  (host_rvalid),
      .host_rdata   (host_rdata),
      .host_starved (host_starved),
      .ram_addr     (ram_addr),
      .ram_we       (ram_we),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata)
   );

   // Initial RAM contents; 0x123 holds 0x5A for the first-read case.
   function automatic logic [7:0] pat(input logic [11:0] a);
      if (a == 12'h123) return 8'h5A;
      return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h27;
   endfunction

   // RAM model: synchronous read, one-cycle latency, read-before-write.
   logic [7:0] mem     [0:4095];
   bit         written [0:4095];
   always @(posedge clk) begin
      ram_rdata <= written[ram_addr] ? mem[ram_addr] : pat(ram_addr);
      if (ram_we) begin
         mem[ram_addr]     <= ram_wdata;
         written[ram_addr] <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Bookkeeping
   // ------------------------------------------------------------------
   int vectors     = 0;
   int miscompares = 0;

   typedef struct packed {
      logic        we;
      logic [11:0] addr;
      logic [7:0]  wdata;
   } hreq_t;

   hreq_t      hq[$];          // host requests still to be granted
   logic [7:0] sb[$];          // expected host read bytes
   logic [7:0] ref_w [int];    // bytes written so far

   // Cycle model state
   logic       m_rd_prev, m_wr_prev, m_wr_slot, m_cap, m_rv;
   logic [7:0] m_cap_val, m_cpu_rdata, m_host_rdata;
   int         m_wait;
   logic       forcing;

   int cyc, a_gnt_cyc, n_gnt, n_we_fff, n_we_all, e;

   function automatic logic [7:0] exp_byte(input logic [11:0] a);
      if (ref_w.exists(int'(a))) return ref_w[int'(a)];
      return pat(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic host_push(input logic we, input logic [11:0] a, input logic [7:0] d);
      hreq_t t;
      t.we    = we;
      t.addr  = a;
      t.wdata = d;
      hq.push_back(t);
   endtask

   task automatic drive_host();
      if (hq.size() > 0) begin
         host_req   = 1'b1;
         host_we    = hq[0].we;
         host_addr  = hq[0].addr;
         host_wdata = hq[0].wdata;
      end else begin
         host_req   = 1'b0;
         host_we    = 1'b0;
         host_addr  = '0;
         host_wdata = '0;
      end
   endtask

   // One clock: check this cycle's outputs at the falling edge against the
   // model, advance the model at the rising edge, then drive the host port.
   task automatic step();
      logic       e_sel, e_rd_edge, e_wr_edge, e_cpu_rd, e_gnt, e_we;
      logic       n_rv;
      logic [7:0] n_cap_val;
      int         n_wait;
      @(negedge clk);
      e_sel     = (cpu_page == 4'h1);
      e_rd_edge = !cpu_RD_n && m_rd_prev && e_sel;
      e_wr_edge = !cpu_WR_n && m_wr_prev && e_sel;
      e_cpu_rd  = e_rd_edge || forcing;
      e_gnt     = !rst && host_req && !e_cpu_rd && !m_wr_slot;
      e_we      = !rst && (m_wr_slot || (e_gnt && host_we));

      chk("cpu_sel", cpu_sel, e_sel);
      chk("host_gnt", host_gnt, e_gnt);
      chk("ram_we", ram_we, e_we);
      if (!rst && e_cpu_rd) chk("rd_addr", ram_addr, cpu_addr);
      if (!rst && m_wr_slot) begin
         chk("wr_addr", ram_addr, cpu_addr);
         chk("wr_data", ram_wdata, cpu_D_o);
      end
      if (e_gnt) begin
         chk("host_addr", ram_addr, host_addr);
         if (host_we) chk("host_wdata", ram_wdata, host_wdata);
      end
      chk("host_rvalid", host_rvalid, m_rv && !rst);
      if (m_rv && !rst && sb.size() > 0) m_host_rdata = sb.pop_front();
      chk("host_rdata", host_rdata, m_host_rdata);
      chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
      chk("host_starved", host_starved, m_wait == c_STARVE);

      if (host_gnt) begin
         a_gnt_cyc = cyc;
         n_gnt++;
      end
      if (ram_we) n_we_all++;
      if (ram_we && ram_addr == 12'hFFF) n_we_fff++;

      n_cap_val = exp_byte(cpu_addr);
      if (!rst && m_wr_slot) ref_w[int'(cpu_addr)] = cpu_D_o;
      if (e_gnt) begin
         if (host_we) ref_w[int'(host_addr)] = host_wdata;
         else         sb.push_back(exp_byte(host_addr));
         void'(hq.pop_front());
      end
      n_rv   = e_gnt && !host_we;
      n_wait = (!host_req || e_gnt) ? 0 : ((m_wait == c_STARVE) ? c_STARVE : m_wait + 1);

      @(posedge clk);
      if (rst) begin
         m_rd_prev    = 1'b0;
         m_wr_prev    = 1'b0;
         m_wr_slot    = 1'b0;
         m_cap        = 1'b0;
         m_rv         = 1'b0;
         m_cap_val    = 8'h00;
         m_cpu_rdata  = 8'h00;
         m_host_rdata = 8'h00;
         m_wait       = 0;
         sb.delete();
      end else begin
         if (m_cap) m_cpu_rdata = m_cap_val;
         m_cap     = e_cpu_rd;
         m_cap_val = n_cap_val;
         m_wr_slot = e_wr_edge;
         m_rd_prev = cpu_RD_n;
         m_wr_prev = cpu_WR_n;
         m_rv      = n_rv;
         m_wait    = n_wait;
      end
      #1;
      cyc++;
      drive_host();
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      rst = 1'b1; cpu_page = 4'h1; cpu_addr = 12'h123; cpu_D_o = 8'h00;
      cpu_RD_n = 1'b0; cpu_WR_n = 1'b1; forcing = 1'b0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      m_rd_prev = 1'b0; m_wr_prev = 1'b0; m_wr_slot = 1'b0; m_cap = 1'b0;
      m_rv = 1'b0; m_cap_val = 8'h00; m_cpu_rdata = 8'h00; m_host_rdata = 8'h00;
      m_wait = 0; cyc = 0; a_gnt_cyc = -1; n_gnt = 0; n_we_fff = 0; n_we_all = 0;
      @(posedge clk); #1;

      // Reset held with RD_n low
      repeat (3) step();
      chk("rst_cpu_rdata", cpu_rdata, 8'h00);
      chk("rst_host_rdata", host_rdata, 8'h00);
      chk("rst_gnt", host_gnt, 1'b0);

      // Release with RD_n still low: no CPU slot, host gets every cycle
      rst = 1'b0;
      for (int i = 0; i < 3; i++) host_push(1'b0, 12'h050 + 12'(i), 8'h00);
      drive_host();
      n_gnt = 0;
      repeat (3) step();
      chk("held_low_gnts", n_gnt, 3);
      cpu_RD_n = 1'b1;
      repeat (2) step();
      cpu_RD_n = 1'b0;
      repeat (2) step();
      chk("first_read", cpu_rdata, 8'h5A);
      cpu_RD_n = 1'b1;
      step();

      // CPU write of 0xC3 to 0xFFF, then read it back
      cpu_addr = 12'hFFF; cpu_D_o = 8'hC3; n_we_fff = 0;
      cpu_WR_n = 1'b0;
      repeat (4) step();
      cpu_WR_n = 1'b1;
      repeat (2) step();
      chk("wr_pulses", n_we_fff, 1);
      cpu_RD_n = 1'b0;
      repeat (2) step();
      chk("rd_fff", cpu_rdata, 8'hC3);
      cpu_RD_n = 1'b1;
      step();

      // Host read arriving in the rd_edge cycle is deferred one cycle
      cpu_addr = 12'h200; cpu_RD_n = 1'b0;
      host_push(1'b0, 12'h010, 8'h00);
      drive_host();
      e = cyc;
      repeat (2) step();
      chk("gnt_delay", a_gnt_cyc, e + 1);
      cpu_RD_n = 1'b1;
      step();
      chk("cpu_unaffected", cpu_rdata, pat(12'h200));
      step();

      // Host streams 8 writes through a 6-cycle CPU read strobe
      for (int i = 0; i < 8; i++) host_push(1'b1, 12'(i), 8'hA0 + 8'(i));
      cpu_addr = 12'h345; cpu_RD_n = 1'b0;
      drive_host();
      n_gnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 6) cpu_RD_n = 1'b1;
         step();
      end
      chk("stream_gnts", n_gnt, 8);
      chk("stream_cpu", cpu_rdata, pat(12'h345));
      for (int i = 0; i < 8; i++) host_push(1'b0, 12'(i), 8'h00);
      drive_host();
      repeat (11) step();

      // Page 2 strobes: no CPU slot, host granted every cycle
      cpu_page = 4'h2; n_gnt = 0; n_we_all = 0;
      for (int i = 0; i < 6; i++) host_push(1'b0, 12'h100 + 12'(i), 8'h00);
      drive_host();
      cpu_RD_n = 1'b0; repeat (2) step();
      cpu_RD_n = 1'b1; step();
      cpu_WR_n = 1'b0; repeat (2) step();
      cpu_WR_n = 1'b1; step();
      chk("p2_gnts", n_gnt, 6);
      chk("p2_no_we", n_we_all, 0);
      chk("p2_sel", cpu_sel, 1'b0);

      // Page switches to ours while WR_n is already low: no write
      cpu_WR_n = 1'b0; step();
      cpu_page = 4'h1; repeat (2) step();
      cpu_WR_n = 1'b1; repeat (3) step();
      chk("midstrobe_no_we", n_we_all, 0);

      // Starvation: CPU slot forced every cycle for 70 cycles
      cpu_addr = 12'h345;
      host_push(1'b0, 12'h777, 8'h00);
      drive_host();
      force dut.w_rd_edge = 1'b1;
      forcing = 1'b1;
      for (int i = 0; i < 70; i++) begin
         if (i == 63) chk("starve_63", host_starved, 1'b0);
         if (i == 64) chk("starve_64", host_starved, 1'b1);
         step();
      end
      release dut.w_rd_edge;
      forcing = 1'b0;
      chk("starve_at_gnt", host_starved, 1'b1);
      step();
      chk("starve_clear", host_starved, 1'b0);
      repeat (3) step();

      chk("sb_empty", sb.size(), 0);
      chk("hq_empty", hq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
